mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single backing-memory port between the instruction-cache refill path and the data-cache refill/writeback path. It grants one cache at a time and sequences a LINE_WORDS-word burst as single-word memory transactions. It returns per-word data and a done pulse to the owner. The owner's stall (icache_stall / dcache_stall into the pipeline registers) stays asserted until the done pulse.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, word width in bits
LINE_WORDS, 4, words per cache line (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ic_req  in  1  icache line-refill request; held until ic_done
ic_addr  in  ADDR_W  icache line address
ic_rvalid  out  1  word valid to icache
ic_rdata  out  DATA_W  refill word
ic_done  out  1  last-word pulse to icache
dc_req  in  1  dcache request; held until dc_done
dc_we  in  1  1 = line writeback, 0 = line refill
dc_addr  in  ADDR_W  dcache line address
dc_wdata  in  LINE_WORDS*DATA_W  writeback line; word 0 in LSBs
dc_rvalid  out  1  word valid to dcache (refill only)
dc_rdata  out  DATA_W  refill word
dc_done  out  1  last-word pulse to dcache
mem_req  out  1  memory transaction request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write word
mem_ack  in  1  memory completes current word; mem_rdata valid this cycle
mem_rdata  in  DATA_W  read word
busy  out  1  a grant is active

Behaviour:
- State machine: IDLE, OWN_I, OWN_D. A 2-bit-or-wider word counter cnt runs 0..LINE_WORDS-1.
- IDLE:
  - dc_req=1 -> OWN_D at the next edge.
  - else ic_req=1 -> OWN_I at the next edge.
  - On the grant edge: capture base = addr with the low log2(LINE_WORDS*DATA_W/8) bits forced to 0; capture dc_we and dc_wdata; set cnt=0.
- OWN_x:
  - mem_req=1 and busy=1.
  - mem_addr = base + cnt*(DATA_W/8).
  - mem_we = captured we (always 0 in OWN_I).
  - mem_wdata = captured word[cnt].
  - Memory may hold off mem_ack any number of cycles; mem_ack on consecutive cycles is legal.
- On mem_ack while owning:
  - Owner's x_rvalid=1 and x_rdata=mem_rdata in the same cycle (combinational). dc_rvalid stays 0 for writebacks.
  - cnt increments.
  - If cnt==LINE_WORDS-1, x_done=1 this cycle and the FSM returns to IDLE at the edge. cnt wraps to 0.
- Requester rule: req drops at the edge that samples done. Requests are resampled in IDLE only, so there is no back-to-back grant without one IDLE cycle.
- Latency, idle to first mem_req: 1 cycle after req. Minimum burst length: LINE_WORDS cycles.
- A request from the other cache during a burst waits. It is granted at the edge after the IDLE cycle.
- Request changes (addr, dc_we, dc_wdata) after the grant are ignored.
- mem_ack in IDLE is ignored: no rvalid, no done.
- Reset values:
  - State IDLE, cnt 0.
  - mem_req, mem_we, busy, all rvalid/done = 0.
  - mem_addr, mem_wdata, rdata outputs = 0 when not owning.
- Reset mid-burst: return to IDLE, mem_req=0 from the following cycle. No done is issued for the aborted burst, and any later stray mem_ack is ignored.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: a last_owner flop (reset = icache) resolves simultaneous dc_req and ic_req in IDLE in favour of the requester that did not own last. Single requests are granted unchanged.
- Undefined: fixed priority, dcache always wins ties. No last_owner flop exists.

Test Plan:
- ic_req only, ic_addr=0x104, memory acks 2 cycles after each mem_req cycle:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - four ic_rvalid pulses carrying the memory data.
  - ic_done on the 4th ack.
  - busy low the next cycle.
- dc_req with dc_we=1, dc_wdata={D3,D2,D1,D0}, dc_addr=0x2000, ack every cycle:
  - mem_we=1 for 4 cycles, writing D0..D3 to 0x2000..0x200C.
  - dc_rvalid never 1; dc_done on the 4th ack.
- ic_req and dc_req rise in the same cycle, both re-requesting after done:
  - Without the macro: dcache is served, then icache, then dcache.
  - With MEM_ARB_RR_EN: dcache, icache, dcache, icache alternate.
- ic_req arrives mid dcache burst: no icache mem_addr appears until one IDLE cycle after dc_done. The icache burst then completes normally.
- rst pulsed after 2 acks of an icache burst, then a stray mem_ack the next cycle:
  - mem_req=0 after the reset edge.
  - no ic_rvalid and no ic_done.
  - a new ic_req restarts from word 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache/memory bundle for mem_arbiter: icache and dcache line requests plus the shared word-wide memory port.
// master = the arbiter, slave = the caches and memory it serves.
interface mem_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         ic_req;
    logic [ADDR_W-1:0]            ic_addr;
    logic                         ic_rvalid;
    logic [DATA_W-1:0]            ic_rdata;
    logic                         ic_done;

    logic                         dc_req;
    logic                         dc_we;
    logic [ADDR_W-1:0]            dc_addr;
    logic [LINE_WORDS*DATA_W-1:0] dc_wdata;
    logic                         dc_rvalid;
    logic [DATA_W-1:0]            dc_rdata;
    logic                         dc_done;

    logic                         mem_req;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         mem_ack;
    logic [DATA_W-1:0]            mem_rdata;

    logic                         busy;

    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        output ic_rvalid, ic_rdata, ic_done, dc_rvalid, dc_rdata, dc_done,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ack, mem_rdata,
        input  ic_rvalid, ic_rdata, ic_done, dc_rvalid, dc_rdata, dc_done,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the memory port to one cache and walks its line as LINE_WORDS single-word transactions; one IDLE cycle between grants.
// MEM_ARB_RR_EN: ties go to the cache that did not own last (else dcache always wins ties).
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int IDX_W   = $clog2(LINE_WORDS);
    localparam int CNT_W   = (IDX_W < 2) ? 2 : IDX_W;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic                            we_q, we_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0] wdata_q, wdata_d;

    logic owning;
    logic ack;
    logic last;
    logic grant_d;
    logic grant_i;

`ifdef MEM_ARB_RR_EN
    // 1 = dcache held the most recent grant
    logic last_dc_q, last_dc_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;

        owning = (state_q == OWN_I) || (state_q == OWN_D);
        // rst gating keeps an aborted burst from emitting a final rvalid/done
        ack    = owning && bus.mem_ack && !rst;
        last   = (cnt_q == CNT_LAST);

`ifdef MEM_ARB_RR_EN
        last_dc_d = last_dc_q;
        grant_d   = bus.dc_req && (!bus.ic_req || !last_dc_q);
`else
        grant_d   = bus.dc_req;
`endif
        grant_i   = bus.ic_req && !grant_d;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = OWN_D;
                    base_d  = bus.dc_addr & BASE_MASK;
                    we_d    = bus.dc_we;
                    wdata_d = bus.dc_wdata;
                    cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
                    last_dc_d = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d = OWN_I;
                    base_d  = bus.ic_addr & BASE_MASK;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
                    last_dc_d = 1'b0;
`endif
                end
            end
            OWN_I, OWN_D: begin
                if (ack) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = owning;
        bus.mem_req   = owning;
        bus.mem_we    = owning && we_q;
        bus.mem_addr  = owning ? (base_q + (ADDR_W'(cnt_q) << BYTE_SH)) : '0;
        bus.mem_wdata = owning ? wdata_q[cnt_q[IDX_W-1:0]] : '0;

        bus.ic_rvalid = ack && (state_q == OWN_I);
        bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
        bus.ic_done   = bus.ic_rvalid && last;

        // writebacks complete with done only; no data goes back to the dcache
        bus.dc_rvalid = ack && (state_q == OWN_D) && !we_q;
        bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;
        bus.dc_done   = ack && (state_q == OWN_D) && last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dc_q <= 1'b0;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory with programmable ack delay plus requesters that re-arm after done.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_delay = 0;
    bit mem_en = 1'b1;
    bit force_ack = 1'b0;
    int wait_cnt = 0;
    int ic_left = 0, dc_left = 0, ic_rearm = 0, dc_rearm = 0;
    logic [31:0] ack_addr_q[$];
    logic [31:0] ack_wdata_q[$];
    logic        ack_we_q[$];
    logic [31:0] ic_data_q[$];
    logic [31:0] dc_data_q[$];
    bit          owner_q[$];      // 1 = dcache burst, 0 = icache burst
    int ic_done_n = 0, dc_done_n = 0, burst_acks = 0, busy_cyc = 0;
    bit prev_req = 1'b0, prev_done = 1'b0;
    int dc_done_cyc = 0, i_start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hXXXX_XXXX;
    endfunction

    task automatic clear_logs();
        ack_addr_q.delete(); ack_wdata_q.delete(); ack_we_q.delete();
        ic_data_q.delete(); dc_data_q.delete(); owner_q.delete();
        ic_done_n = 0; dc_done_n = 0; busy_cyc = 0;
    endtask

    // One clock: drive memory response after negedge, sample #1 later, update requesters.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (ic_rearm > 0) begin ic_rearm--; if (ic_rearm == 0) bus.ic_req = 1'b1; end
        if (dc_rearm > 0) begin dc_rearm--; if (dc_rearm == 0) bus.dc_req = 1'b1; end
        if (force_ack) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        end else if (mem_en && bus.mem_req && wait_cnt >= ack_delay) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = mdat(bus.mem_addr); wait_cnt = 0;
        end else begin
            bus.mem_ack = 1'b0; bus.mem_rdata = '0;
            if (bus.mem_req) wait_cnt++;
        end
        #1;
        if (bus.mem_req && !prev_req) begin
            owner_q.push_back(bus.mem_addr[13]);
            burst_acks = 0;
            if (!bus.mem_addr[13]) i_start_cyc = cyc;
        end
        if (prev_done) check("busy_after_done", {63'd0, bus.busy}, 64'd0);
        if (bus.busy) busy_cyc++;
        prev_req  = bus.mem_req;
        prev_done = bus.ic_done | bus.dc_done;
        if (bus.mem_ack && bus.mem_req) begin
            ack_addr_q.push_back(bus.mem_addr);
            ack_wdata_q.push_back(bus.mem_wdata);
            ack_we_q.push_back(bus.mem_we);
            burst_acks++;
        end
        if (bus.ic_rvalid) ic_data_q.push_back(bus.ic_rdata);
        if (bus.dc_rvalid) dc_data_q.push_back(bus.dc_rdata);
        // requester drops at the done edge and stays low through the IDLE cycle before re-arming
        if (bus.ic_done) begin
            ic_done_n++;
            check("ic_done_on_last_ack", 64'(burst_acks), 64'd4);
            bus.ic_req = 1'b0;
            if (ic_left > 0) ic_left--;
            if (ic_left > 0) ic_rearm = 2;
        end
        if (bus.dc_done) begin
            dc_done_n++;
            dc_done_cyc = cyc;
            check("dc_done_on_last_ack", 64'(burst_acks), 64'd4);
            bus.dc_req = 1'b0;
            if (dc_left > 0) dc_left--;
            if (dc_left > 0) dc_rearm = 2;
        end
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((ic_left > 0 || dc_left > 0 || bus.busy) && n < budget);
        check({tag, "_timeout"}, {63'd0, n < budget}, 64'd1);
    endtask

    logic [127:0] line_w;
    bit exp_own[4];

    initial begin
        rst = 1'b1;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) cycle();

        // reset state
        check("rst_mem_req",   {63'd0, bus.mem_req},   64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_mem_we",    {63'd0, bus.mem_we},    64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),      64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata),     64'd0);
        check("rst_ic_rvalid", {63'd0, bus.ic_rvalid}, 64'd0);
        check("rst_ic_done",   {63'd0, bus.ic_done},   64'd0);
        check("rst_dc_rvalid", {63'd0, bus.dc_rvalid}, 64'd0);
        check("rst_dc_done",   {63'd0, bus.dc_done},   64'd0);
        check("rst_ic_rdata",  64'(bus.ic_rdata),      64'd0);
        check("rst_dc_rdata",  64'(bus.dc_rdata),      64'd0);
        rst = 1'b0;
        cycle();

        // ack in IDLE is ignored
        force_ack = 1'b1;
        cycle();
        check("idle_ack_ic_rvalid", {63'd0, bus.ic_rvalid}, 64'd0);
        check("idle_ack_dc_rvalid", {63'd0, bus.dc_rvalid}, 64'd0);
        check("idle_ack_ic_done",   {63'd0, bus.ic_done},   64'd0);
        check("idle_ack_dc_done",   {63'd0, bus.dc_done},   64'd0);
        force_ack = 1'b0;
        cycle();

        // T1: icache refill, ack 2 cycles after each word's first mem_req cycle
        clear_logs();
        ack_delay = 2; wait_cnt = 0;
        bus.ic_addr = 32'h104; bus.ic_req = 1'b1; ic_left = 1;
        check("t1_no_req_before_grant", {63'd0, bus.mem_req}, 64'd0);
        cycle();
        check("t1_latency_req",  {63'd0, bus.mem_req}, 64'd1);
        check("t1_first_addr",   64'(bus.mem_addr),    64'h100);
        run_idle(60, "t1");
        check("t1_n_acks", 64'(ack_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 64'(qget(ack_addr_q, i)), 64'(32'h100 + 32'(4 * i)));
            check($sformatf("t1_data%0d", i), 64'(qget(ic_data_q, i)), 64'(mdat(32'h100 + 32'(4 * i))));
        end
        check("t1_we_first",  {63'd0, ack_we_q.size() > 0 ? ack_we_q[0] : 1'bx}, 64'd0);
        check("t1_ic_done_n", 64'(ic_done_n), 64'd1);
        check("t1_dc_rvalid", 64'(dc_data_q.size()), 64'd0);
        check("t1_busy_cycles", 64'(busy_cyc), 64'd12);

        // T3: simultaneous requests, each cache asks for two lines
        clear_logs();
        ack_delay = 0; wait_cnt = 0;
        bus.ic_addr = 32'h1040; bus.dc_addr = 32'h2040; bus.dc_we = 1'b0;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1; ic_left = 2; dc_left = 2;
        run_idle(200, "t3");
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
        check("t3_n_grants", 64'(owner_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_owner%0d", i), {63'd0, i < owner_q.size() ? owner_q[i] : 1'bx}, {63'd0, exp_own[i]});
        check("t3_ic_words", 64'(ic_data_q.size()), 64'd8);
        check("t3_dc_words", 64'(dc_data_q.size()), 64'd8);
        check("t3_dc_data0", 64'(qget(dc_data_q, 0)), 64'(mdat(32'h2040)));

        // T2: dcache writeback, ack every cycle; request fields scrambled after the grant
        clear_logs();
        ack_delay = 0; wait_cnt = 0;
        line_w = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        bus.dc_addr = 32'h2000; bus.dc_we = 1'b1; bus.dc_wdata = line_w;
        bus.dc_req = 1'b1; dc_left = 1;
        cycle();
        bus.dc_addr = 32'h3FF0; bus.dc_we = 1'b0; bus.dc_wdata = '1;
        run_idle(40, "t2");
        check("t2_n_acks", 64'(ack_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i),  64'(qget(ack_addr_q, i)),  64'(32'h2000 + 32'(4 * i)));
            check($sformatf("t2_wdata%0d", i), 64'(qget(ack_wdata_q, i)), 64'(line_w[32*i +: 32]));
            check($sformatf("t2_we%0d", i),    {63'd0, i < ack_we_q.size() ? ack_we_q[i] : 1'bx}, 64'd1);
        end
        check("t2_dc_rvalid",   64'(dc_data_q.size()), 64'd0);
        check("t2_dc_done_n",   64'(dc_done_n),        64'd1);
        check("t2_busy_cycles", 64'(busy_cyc),         64'd4);
        bus.dc_we = 1'b0;

        // T6: tie with dcache as last owner
        clear_logs();
        bus.ic_addr = 32'h100; bus.dc_addr = 32'h2000;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1; ic_left = 1; dc_left = 1;
        run_idle(100, "t6");
`ifdef MEM_ARB_RR_EN
        check("t6_first_owner",  {63'd0, owner_q.size() > 0 ? owner_q[0] : 1'bx}, 64'd0);
        check("t6_second_owner", {63'd0, owner_q.size() > 1 ? owner_q[1] : 1'bx}, 64'd1);
`else
        check("t6_first_owner",  {63'd0, owner_q.size() > 0 ? owner_q[0] : 1'bx}, 64'd1);
        check("t6_second_owner", {63'd0, owner_q.size() > 1 ? owner_q[1] : 1'bx}, 64'd0);
`endif

        // T4: icache request arrives mid dcache refill
        clear_logs();
        ack_delay = 1; wait_cnt = 0;
        bus.dc_addr = 32'h2000; bus.dc_we = 1'b0; bus.dc_req = 1'b1; dc_left = 1;
        for (int n = 0; n < 20 && dc_data_q.size() < 1; n++) cycle();
        bus.ic_addr = 32'h108; bus.ic_req = 1'b1; ic_left = 1;
        run_idle(100, "t4");
        check("t4_n_grants", 64'(owner_q.size()), 64'd2);
        check("t4_owner0", {63'd0, owner_q.size() > 0 ? owner_q[0] : 1'bx}, 64'd1);
        check("t4_owner1", {63'd0, owner_q.size() > 1 ? owner_q[1] : 1'bx}, 64'd0);
        check("t4_idle_gap", 64'(i_start_cyc - dc_done_cyc), 64'd2);
        check("t4_ic_addr0", 64'(qget(ack_addr_q, 4)), 64'h100);
        check("t4_ic_addr3", 64'(qget(ack_addr_q, 7)), 64'h10C);
        check("t4_ic_words", 64'(ic_data_q.size()), 64'd4);
        check("t4_ic_done_n", 64'(ic_done_n), 64'd1);

        // T5: reset after two acks, then a stray ack
        clear_logs();
        ack_delay = 0; wait_cnt = 0;
        bus.ic_addr = 32'h104; bus.ic_req = 1'b1; ic_left = 1;
        for (int n = 0; n < 20 && ack_addr_q.size() < 2; n++) cycle();
        check("t5_two_acks", 64'(ack_addr_q.size()), 64'd2);
        rst = 1'b1; mem_en = 1'b0; bus.ic_req = 1'b0; ic_left = 0;
        cycle();
        check("t5_req_after_rst",  {63'd0, bus.mem_req}, 64'd0);
        check("t5_busy_after_rst", {63'd0, bus.busy},    64'd0);
        rst = 1'b0; force_ack = 1'b1;
        cycle();
        check("t5_stray_rvalid", {63'd0, bus.ic_rvalid}, 64'd0);
        check("t5_stray_done",   {63'd0, bus.ic_done},   64'd0);
        force_ack = 1'b0;
        check("t5_words_kept", 64'(ic_data_q.size()), 64'd2);
        check("t5_no_done",    64'(ic_done_n),        64'd0);
        clear_logs();
        mem_en = 1'b1; wait_cnt = 0;
        bus.ic_req = 1'b1; ic_left = 1;
        run_idle(60, "t5");
        check("t5_restart_addr0", 64'(qget(ack_addr_q, 0)), 64'h100);
        check("t5_restart_words", 64'(ic_data_q.size()),   64'd4);
        check("t5_restart_done",  64'(ic_done_n),          64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
